// File: rtl/mu0_mem_sequencer.sv
// Multicycle memory front-end for the MU0 core: instruction fetch, operand read or
// store on a single-port RAM bus with waitrequest, then a one-cycle execute strobe.
module mu0_mem_sequencer #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] core_pc,
    input  logic [DATA_WIDTH-1:0] core_writedata,
    input  logic                  core_running,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  read_valid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    output logic [31:0]           retired_count,
    output logic [2:0]            fsm_state
);

    // Bus handshake: a request (mem_read or mem_write, never both) is accepted on a
    // rising edge where it is high and mem_waitrequest is low. Address, data and the
    // request stay stable until then. Read data is sampled READ_LATENCY edges after
    // acceptance.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_REQ = 3'd1,
        FETCH_LAT = 3'd2,
        OPND_REQ  = 3'd3,
        OPND_LAT  = 3'd4,
        STORE_REQ = 3'd5,
        EXEC      = 3'd6
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] lat_cnt;
    logic       accepted;
    logic       sample_now;
    logic [3:0] fetched_op;

    assign accepted   = (mem_read | mem_write) & ~mem_waitrequest;
    assign sample_now = (lat_cnt == 3'd0);
    assign fetched_op = mem_readdata[DATA_WIDTH-1 -: 4];
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (core_running) state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                // running dropping here (STP retired on the previous edge) parks the sequencer
                if (!core_running)  state_next = IDLE;
                else if (accepted)  state_next = FETCH_LAT;
            end
            FETCH_LAT: begin
                if (sample_now) begin
                    case (fetched_op)
                        4'd0, 4'd2, 4'd3: state_next = OPND_REQ;
                        4'd1:             state_next = STORE_REQ;
                        default:          state_next = EXEC;
                    endcase
                end
            end
            OPND_REQ: begin
                if (accepted) state_next = OPND_LAT;
            end
            OPND_LAT: begin
                if (sample_now) state_next = EXEC;
            end
            STORE_REQ: begin
                if (accepted) state_next = EXEC;
            end
            EXEC: begin
                state_next = FETCH_REQ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_address   = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = '0;
        read_valid    = 1'b0;
        case (state)
            FETCH_REQ: begin
                mem_address = core_pc;
                mem_read    = core_running;
            end
            OPND_REQ: begin
                mem_address = instr[ADDR_WIDTH-1:0];
                mem_read    = 1'b1;
            end
            STORE_REQ: begin
                mem_address   = instr[ADDR_WIDTH-1:0];
                mem_write     = 1'b1;
                mem_writedata = core_writedata;
            end
            EXEC: begin
                read_valid = 1'b1;
            end
            default: begin
                mem_address = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt <= 3'd0;
        end else if (accepted) begin
            lat_cnt <= LAT_LOAD;
        end else if ((state == FETCH_LAT || state == OPND_LAT) && lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr         <= '0;
            readdata      <= '0;
            retired_count <= 32'd0;
        end else begin
            if (state == FETCH_LAT && sample_now) instr <= mem_readdata;
            if (state == OPND_LAT && sample_now)  readdata <= mem_readdata;
            if (state == EXEC)                    retired_count <= retired_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_mu0_mem_sequencer.sv
// Directed bench for mu0_mem_sequencer: instance 0 at READ_LATENCY=1, instance 1 at
// READ_LATENCY=3, each with a small RAM model and a minimal MU0 core model.
module tb_mu0_mem_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH_REQ = 3'd1, S_FETCH_LAT = 3'd2,
                           S_OPND_REQ = 3'd3, S_STORE_REQ = 3'd5;

    logic        clk;
    logic        rst_s    [2];
    logic [11:0] pc_s     [2];
    logic [15:0] acc_s    [2];
    logic        run_s    [2];
    logic [15:0] instr_s  [2];
    logic [15:0] rdata_s  [2];
    logic        rv_s     [2];
    logic [11:0] maddr_s  [2];
    logic        mrd_s    [2];
    logic        mwr_s    [2];
    logic [15:0] mwdata_s [2];
    logic        wait_s   [2];
    logic [15:0] mrdata_s [2];
    logic [31:0] ret_s    [2];
    logic [2:0]  st_s     [2];

    logic [15:0] ram [2][4096];
    logic [3:0]  pv  [2];
    logic [15:0] pd  [2][4];
    logic        pend_v [2];
    logic [15:0] pend_d [2];
    int          lat_of [2];
    int          wcyc   [2];
    logic [11:0] rd_log0[$];
    logic [11:0] rd_log1[$];
    logic [11:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [11:0] exp_q[$];

    int n_total = 0;
    int n_bad   = 0;

    mu0_mem_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst_s[0]), .core_pc(pc_s[0]), .core_writedata(acc_s[0]),
        .core_running(run_s[0]), .instr(instr_s[0]), .readdata(rdata_s[0]),
        .read_valid(rv_s[0]), .mem_address(maddr_s[0]), .mem_read(mrd_s[0]),
        .mem_write(mwr_s[0]), .mem_writedata(mwdata_s[0]), .mem_waitrequest(wait_s[0]),
        .mem_readdata(mrdata_s[0]), .retired_count(ret_s[0]), .fsm_state(st_s[0])
    );

    mu0_mem_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .READ_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst_s[1]), .core_pc(pc_s[1]), .core_writedata(acc_s[1]),
        .core_running(run_s[1]), .instr(instr_s[1]), .readdata(rdata_s[1]),
        .read_valid(rv_s[1]), .mem_address(maddr_s[1]), .mem_read(mrd_s[1]),
        .mem_write(mwr_s[1]), .mem_writedata(mwdata_s[1]), .mem_waitrequest(wait_s[1]),
        .mem_readdata(mrdata_s[1]), .retired_count(ret_s[1]), .fsm_state(st_s[1])
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish within 200000");
        $fatal(1, "watchdog expired");
    end

    // RAM model: acceptance decided half a cycle before the edge; read data appears only
    // in the window where the DUT should sample it, garbage otherwise.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 3; i > 0; i--) begin
                pv[d][i] = pv[d][i-1];
                pd[d][i] = pd[d][i-1];
            end
            pv[d][0]  = pend_v[d];
            pd[d][0]  = pend_d[d];
            pend_v[d] = 1'b0;
            if (rst_s[d] && mrd_s[d] && !wait_s[d]) begin
                pend_v[d] = 1'b1;
                pend_d[d] = ram[d][maddr_s[d]];
                if (d == 0) rd_log0.push_back(maddr_s[d]);
                else        rd_log1.push_back(maddr_s[d]);
            end
            if (rst_s[d] && mwr_s[d]) begin
                wcyc[d]++;
                if (!wait_s[d]) begin
                    ram[d][maddr_s[d]] = mwdata_s[d];
                    if (d == 0) begin
                        wr_addr_q.push_back(maddr_s[d]);
                        wr_data_q.push_back(mwdata_s[d]);
                    end
                end
            end
            mrdata_s[d] = pv[d][lat_of[d]-1] ? pd[d][lat_of[d]-1] : 16'hdead;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic core_step(input int d);
        logic [3:0]  op;
        logic [11:0] a;
        op = instr_s[d][15:12];
        a  = instr_s[d][11:0];
        case (op)
            4'd0: begin acc_s[d] = rdata_s[d];            pc_s[d] = pc_s[d] + 12'd1; end
            4'd2: begin acc_s[d] = acc_s[d] + rdata_s[d]; pc_s[d] = pc_s[d] + 12'd1; end
            4'd3: begin acc_s[d] = acc_s[d] - rdata_s[d]; pc_s[d] = pc_s[d] + 12'd1; end
            4'd4: pc_s[d] = a;
            4'd5: pc_s[d] = acc_s[d][15] ? pc_s[d] + 12'd1 : a;
            4'd6: pc_s[d] = (acc_s[d] != 16'd0) ? a : pc_s[d] + 12'd1;
            4'd7: run_s[d] = 1'b0;
            default: pc_s[d] = pc_s[d] + 12'd1;
        endcase
    endtask

    // One clock; the core model reacts to the execute strobe during the EXEC cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            if (rst_s[d] && rv_s[d]) core_step(d);
    endtask

    // Reset instance d, release it with running=1 and step into FETCH_REQ.
    task automatic do_reset(input int d);
        rst_s[d] = 1'b0;
        run_s[d] = 1'b0;
        pc_s[d]  = 12'd0;
        acc_s[d] = 16'd0;
        tick();
        tick();
        rd_log0.delete(); rd_log1.delete(); wr_addr_q.delete(); wr_data_q.delete();
        wcyc[0] = 0; wcyc[1] = 0;
        run_s[d] = 1'b1;
        rst_s[d] = 1'b1;
        tick();
    endtask

    // Starts in a FETCH_REQ cycle, ends in the cycle after the execute strobe.
    task automatic exec_one(input int d, output int lat, output logic [15:0] ins,
                            output logic [15:0] rdd);
        int   n;
        logic seen;
        n = 1; seen = 1'b0; ins = '0; rdd = '0;
        while (!seen && n <= 40) begin
            if (rv_s[d]) begin
                seen = 1'b1;
                ins  = instr_s[d];
                rdd  = rdata_s[d];
            end else begin
                tick();
                n++;
            end
        end
        check("rv_seen", {31'd0, seen}, 32'd1);
        lat = n;
        tick();
        check("rv_one_cycle", {31'd0, rv_s[d]}, 32'd0);
    endtask

    task automatic check_reads(input int d, input string tag);
        int sz;
        sz = (d == 0) ? rd_log0.size() : rd_log1.size();
        check({tag, "_count"}, sz, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sz; i++)
            check({tag, "_addr"}, (d == 0) ? rd_log0[i] : rd_log1[i], exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, st_s[0], S_IDLE);
        check({tag, "_instr"}, instr_s[0], 0);
        check({tag, "_readdata"}, rdata_s[0], 0);
        check({tag, "_read_valid"}, rv_s[0], 0);
        check({tag, "_mem_read"}, mrd_s[0], 0);
        check({tag, "_mem_write"}, mwr_s[0], 0);
        check({tag, "_mem_address"}, maddr_s[0], 0);
        check({tag, "_mem_writedata"}, mwdata_s[0], 0);
        check({tag, "_retired"}, ret_s[0], 0);
    endtask

    initial begin
        int          lat;
        int          cnt;
        logic [15:0] ins;
        logic [15:0] rdd;

        lat_of[0] = 1; lat_of[1] = 3;
        for (int d = 0; d < 2; d++) begin
            pv[d] = '0; pend_v[d] = 1'b0; pend_d[d] = '0; wcyc[d] = 0;
            wait_s[d] = 1'b0; run_s[d] = 1'b0; pc_s[d] = '0; acc_s[d] = '0;
            mrdata_s[d] = 16'hdead; rst_s[d] = 1'b1;
            for (int i = 0; i < 4; i++) pd[d][i] = '0;
            for (int a = 0; a < 4096; a++) ram[d][a] = 16'd0;
        end

        // 1: async reset values, then a lone STP
        #2;
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        #1;
        check_reset_outputs("reset");
        ram[0][0] = 16'h7000;
        do_reset(0);
        check("t1_state_fr", st_s[0], S_FETCH_REQ);
        check("t1_fetch_addr", maddr_s[0], 12'h000);
        check("t1_fetch_rd", mrd_s[0], 1);
        exec_one(0, lat, ins, rdd);
        check("t1_latency", lat, 3);
        check("t1_instr", ins, 16'h7000);
        check("t1_stp_no_req", mrd_s[0], 0);
        tick();
        check("t1_idle", st_s[0], S_IDLE);
        check("t1_retired", ret_s[0], 1);

        // 2: LDA 0x010; ADD 0x011; STO 0x012; STP
        ram[0][0] = 16'h0010; ram[0][1] = 16'h2011; ram[0][2] = 16'h1012; ram[0][3] = 16'h7000;
        ram[0][12'h010] = 16'd5; ram[0][12'h011] = 16'd7; ram[0][12'h012] = 16'd0;
        do_reset(0);
        exec_one(0, lat, ins, rdd);
        check("t2_lda_lat", lat, 5);
        check("t2_lda_rd", rdd, 16'd5);
        exec_one(0, lat, ins, rdd);
        check("t2_add_lat", lat, 5);
        check("t2_add_rd", rdd, 16'd7);
        exec_one(0, lat, ins, rdd);
        check("t2_sto_lat", lat, 4);
        check("t2_sto_rd_kept", rdd, 16'd7);
        exec_one(0, lat, ins, rdd);
        check("t2_stp_lat", lat, 3);
        tick();
        check("t2_idle", st_s[0], S_IDLE);
        check("t2_retired", ret_s[0], 4);
        check("t2_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) begin
            check("t2_wr_addr", wr_addr_q[0], 12'h012);
            check("t2_wr_data", wr_data_q[0], 16'd12);
        end
        check("t2_wr_cycles", wcyc[0], 1);
        check("t2_ram_12", ram[0][12'h012], 16'd12);
        exp_q = '{12'h000, 12'h010, 12'h001, 12'h011, 12'h002, 12'h003};
        check_reads(0, "t2_reads");

        // 3: three waitrequest cycles on the operand read of LDA 0x020
        ram[0][0] = 16'h0020; ram[0][1] = 16'h7000; ram[0][12'h020] = 16'habcd;
        do_reset(0);
        cnt = 1;
        tick(); cnt++;
        tick(); cnt++;
        wait_s[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wait_s[0] = 1'b0;
            check("t3_stall_state", st_s[0], S_OPND_REQ);
            check("t3_stall_addr", maddr_s[0], 12'h020);
            check("t3_stall_rd", mrd_s[0], 1);
            if (i < 3) begin tick(); cnt++; end
        end
        while (!rv_s[0] && cnt < 40) begin tick(); cnt++; end
        check("t3_latency", cnt, 8);
        check("t3_readdata", rdata_s[0], 16'habcd);
        tick();
        exec_one(0, lat, ins, rdd);
        check("t3_stp_lat", lat, 3);
        exp_q = '{12'h000, 12'h020, 12'h001};
        check_reads(0, "t3_reads");

        // 4: READ_LATENCY=3, JMP 0x005 then STP
        ram[1][0] = 16'h4005; ram[1][5] = 16'h7000;
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_lat_state", st_s[1], S_FETCH_LAT);
            check("t4_instr_hold", instr_s[1], 16'h0000);
        end
        tick();
        check("t4_rv_cycle5", rv_s[1], 1);
        check("t4_instr", instr_s[1], 16'h4005);
        tick();
        check("t4_next_addr", maddr_s[1], 12'h005);
        check("t4_next_rd", mrd_s[1], 1);
        exec_one(1, lat, ins, rdd);
        check("t4_stp_lat", lat, 5);
        check("t4_stp_instr", ins, 16'h7000);
        exp_q = '{12'h000, 12'h005};
        check_reads(1, "t4_reads");

        // 5: async reset while STORE_REQ is stalled
        ram[0][0] = 16'h1030; ram[0][12'h030] = 16'd0;
        do_reset(0);
        acc_s[0] = 16'h0055;
        tick();
        tick();
        wait_s[0] = 1'b1;
        check("t5_store_state", st_s[0], S_STORE_REQ);
        check("t5_store_wr", mwr_s[0], 1);
        check("t5_store_addr", maddr_s[0], 12'h030);
        check("t5_store_data", mwdata_s[0], 16'h0055);
        tick();
        #2;
        rst_s[0] = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        tick();
        wait_s[0] = 1'b0;
        tick();
        pc_s[0] = 12'h008; ram[0][8] = 16'h7000; run_s[0] = 1'b1; rst_s[0] = 1'b1;
        tick();
        check("t5_restart_addr", maddr_s[0], 12'h008);
        check("t5_restart_rd", mrd_s[0], 1);
        exec_one(0, lat, ins, rdd);
        check("t5_stp_lat", lat, 3);
        check("t5_no_write", wr_addr_q.size(), 0);
        check("t5_ram_30", ram[0][12'h030], 16'd0);
        check("t5_retired", ret_s[0], 1);

        // 6: undefined opcode 0xF makes no operand access
        ram[0][0] = 16'hf123; ram[0][1] = 16'h7000;
        do_reset(0);
        exec_one(0, lat, ins, rdd);
        check("t6_lat", lat, 3);
        check("t6_instr", ins, 16'hf123);
        check("t6_readdata_kept", rdd, 16'h0000);
        exec_one(0, lat, ins, rdd);
        check("t6_stp_lat", lat, 3);
        tick();
        check("t6_retired", ret_s[0], 2);
        check("t6_no_write", wr_addr_q.size(), 0);
        exp_q = '{12'h000, 12'h001};
        check_reads(0, "t6_reads");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
